// File: rtl/crc_engine.sv
// -----------------------------------------------------------------------------
// crc_engine
//   Framed, parametrised CRC engine. Words of DATA_BITS enter through a
//   valid/ready handshake and are folded into the CRC register BPC bits per
//   clock. Polynomial, init value, input/output reflection, final XOR and an
//   expected value are latched per frame on the word that carries in_first.
//
// Parameters
//   VERI_BITS  CRC width (3..64)
//   DATA_BITS  input word width
//   BPC        bits folded per clock; must divide DATA_BITS
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cfg_poly/init/xorout/expect, cfg_refin/refout
//                       frame configuration, sampled with an in_first word
//   in_valid/in_ready   input word handshake
//   in_data, in_first, in_last
//                       word payload and frame delimiters
//   out_valid/out_ready result handshake
//   out_crc, out_match  final CRC and its comparison with the expected value
//   dbg_state           current FSM state (0 idle, 1 calc, 2 done)
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source keeps valid and its payload stable until that edge;
// ready never depends combinationally on valid. in_ready is high only in the
// idle state (and never while reset is applied); out_valid is high only in
// the done state, with out_crc/out_match stable until out_ready is seen.
// -----------------------------------------------------------------------------
module crc_engine #(
  parameter int VERI_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int BPC       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VERI_BITS-1:0] cfg_poly,
  input  logic [VERI_BITS-1:0] cfg_init,
  input  logic [VERI_BITS-1:0] cfg_xorout,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
  input  logic [VERI_BITS-1:0] cfg_expect,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VERI_BITS-1:0] out_crc,
  output logic                 out_match,
  output logic [1:0]           dbg_state
);

  localparam int N_BEATS = DATA_BITS / BPC;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  generate
    if ((BPC < 1) || (BPC > DATA_BITS) || ((DATA_BITS % BPC) != 0)) begin : g_bad_bpc
      $error("crc_engine: BPC must divide DATA_BITS");
    end
    if ((VERI_BITS < 3) || (VERI_BITS > 64)) begin : g_bad_width
      $error("crc_engine: VERI_BITS must be within 3..64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [DATA_BITS-1:0] rev_data(input logic [DATA_BITS-1:0] v);
    logic [DATA_BITS-1:0] r;
    for (int i = 0; i < DATA_BITS; i++) r[i] = v[DATA_BITS-1-i];
    return r;
  endfunction

  function automatic logic [VERI_BITS-1:0] rev_crc(input logic [VERI_BITS-1:0] v);
    logic [VERI_BITS-1:0] r;
    for (int i = 0; i < VERI_BITS; i++) r[i] = v[VERI_BITS-1-i];
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [VERI_BITS-1:0] crc_q, crc_step, crc_final;
  logic [DATA_BITS-1:0] shift_q, load_word;
  logic [BEAT_W-1:0]    beat_q;
  logic                 last_q;
  logic [VERI_BITS-1:0] poly_q, xorout_q, expect_q;
  logic                 refin_q, refout_q;
  logic                 load_refin;
  logic                 accept;
  logic                 calc_done;

  assign in_ready  = rst && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign calc_done = (state_q == S_CALC) && (beat_q == LAST_BEAT);
  assign dbg_state = state_q;

  // The buffer is always consumed MSB first; for a reflected frame the word
  // is bit-reversed once on load, so bit 0 of in_data is fed first.
  assign load_refin = in_first ? cfg_refin : refin_q;
  assign load_word  = load_refin ? rev_data(in_data) : in_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_CALC;
      S_CALC:  if (calc_done) state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------- BPC serial steps
  always_comb begin
    crc_step = crc_q;
    for (int i = 0; i < BPC; i++) begin
      if (crc_step[VERI_BITS-1] ^ shift_q[DATA_BITS-1-i])
        crc_step = {crc_step[VERI_BITS-2:0], 1'b0} ^ poly_q;
      else
        crc_step = {crc_step[VERI_BITS-2:0], 1'b0};
    end
    crc_final = (refout_q ? rev_crc(crc_step) : crc_step) ^ xorout_q;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q     <= '0;
      shift_q   <= '0;
      beat_q    <= '0;
      last_q    <= 1'b0;
      poly_q    <= '0;
      xorout_q  <= '0;
      expect_q  <= '0;
      refin_q   <= 1'b0;
      refout_q  <= 1'b0;
      out_crc   <= '0;
      out_match <= 1'b0;
    end else if (accept) begin
      shift_q <= load_word;
      last_q  <= in_last;
      beat_q  <= '0;
      // A first word (even mid-frame) restarts from cfg_init; otherwise
      // the register carries over, including across a finished frame.
      if (in_first) begin
        crc_q    <= cfg_init;
        poly_q   <= cfg_poly;
        xorout_q <= cfg_xorout;
        expect_q <= cfg_expect;
        refin_q  <= cfg_refin;
        refout_q <= cfg_refout;
      end
    end else if (state_q == S_CALC) begin
      crc_q   <= crc_step;
      shift_q <= shift_q << BPC;
      beat_q  <= beat_q + 1'b1;
      if (calc_done && last_q) begin
        out_crc   <= crc_final;
        out_match <= (crc_final == expect_q);
      end
    end
  end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
- Parametrised, framed CRC engine; successor to the bit-serial CRC blocks.
- Accepts DATA_BITS-wide words through a valid/ready handshake and processes BPC bits per clock.
- Runtime-configurable per frame: polynomial, init value, input/output reflection, final XOR and expected-value check.
- Serves the Ethernet MAC, SD controller and flash paths, one instance per bus width.

Parameters:
VERI_BITS, 32, CRC width (highest polynomial exponent); 3..64
DATA_BITS, 32, input word width; >= BPC
BPC, 8, bits processed per clock; must divide DATA_BITS (elaboration error otherwise)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous reset, active-low (0 = reset)
cfg_poly  in  VERI_BITS  polynomial without the implicit top 1; latched on the in_first handshake
cfg_init  in  VERI_BITS  initial CRC register value; latched on in_first
cfg_xorout  in  VERI_BITS  final XOR mask; latched on in_first
cfg_refin  in  1  1 = word processed LSB first; latched on in_first
cfg_refout  in  1  1 = CRC register bit-reversed before xorout; latched on in_first
cfg_expect  in  VERI_BITS  value compared against the final CRC; latched on in_first
in_valid  in  1  input word valid
in_ready  out  1  engine can accept a word
in_data  in  DATA_BITS  input word
in_first  in  1  word starts a frame
in_last  in  1  word ends a frame
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_crc  out  VERI_BITS  final CRC
out_match  out  1  out_crc == cfg_expect

Behaviour:
- States: S_IDLE (in_ready=1), S_CALC, S_DONE (out_valid=1).
- Handshake: a word is accepted on a clk edge with in_valid && in_ready. in_ready is asserted only in S_IDLE; in_valid in other states is ignored and not lost: the source holds it.
- On accept:
  - Load the word into the shift buffer, store in_last, go to S_CALC with beat counter = 0.
  - If in_first: CRC register <= cfg_init and all cfg_* are latched; otherwise the CRC carries over from the previous word.
- S_CALC, each edge, BPC serial steps unrolled combinationally. Each step: fb = crc[MSB] ^ bit; crc = (crc << 1) ^ (fb ? poly : 0).
  - Bit order: refin=0 feeds in_data[DATA_BITS-1] down to [0]; refin=1 feeds [0] up to [DATA_BITS-1] (little-endian bytes, each LSB first).
  - The buffer shifts by BPC per edge.
- After DATA_BITS/BPC edges:
  - last=0 -> S_IDLE.
  - last=1 -> S_DONE, and out_crc <= (refout ? bitrev(crc) : crc) ^ xorout; out_match registered the same edge.
- Latency: BPC=DATA_BITS gives accept edge, plus 1 calc edge, then out_valid. In general, out_valid rises N+1 edges after accepting the last word, where N = DATA_BITS/BPC.
- Throughput: one word per N+1 cycles.
- S_DONE: out_crc and out_match are held stable while out_valid=1 && out_ready=0. On the out_ready edge -> S_IDLE; out_valid drops and out_crc holds its last value.
- First/last combinations:
  - in_first && in_last in one word is a single-word frame.
  - A word without in_first arriving after a completed frame continues from the post-frame CRC register (pre-xorout value). This is not an error.
  - in_first mid-frame restarts the frame; the earlier partial CRC is discarded.
- Reset (rst=0, asynchronous, any state including mid-S_CALC or S_DONE):
  - state = S_IDLE; crc, out_crc = 0; out_valid, out_match = 0; in_ready = 0 while rst=0, 1 the first cycle after release.
  - Latched cfg, all zero.
  - Aborted frames produce no output.
- Output reset values: in_ready=0 (during reset), out_valid=0, out_crc=0, out_match=0.

Test Plan:
- CRC-32 (VERI_BITS=32, DATA_BITS=8, BPC=8), poly 0x04C11DB7, init/xorout 0xFFFFFFFF, refin=refout=1, expect 0xCBF43926, bytes "123456789" with first on '1', last on '9' -> out_crc=0xCBF43926, out_match=1, out_valid exactly 2 edges after the '9' accept.
- CRC-16/CCITT-FALSE (VERI_BITS=16, DATA_BITS=8, BPC=1), poly 0x1021, init 0xFFFF, xorout 0, no reflection, "123456789" -> 0x29B1. in_ready low for 8 cycles after each accept, 9 cycles per byte.
- CRC-8 (VERI_BITS=8, DATA_BITS=16, BPC=4), poly 0x07, init 0, expect 0x00, words 0x3132, 0x3334, 0x3536, 0x3738 then frame ends: out_crc matches a golden model for "12345678", out_match=0. Repeat with refin=1 and check byte-swapped ordering against the model.
- Backpressure: hold out_ready=0 for 10 cycles in S_DONE with in_valid=1 -> out_crc stable, in_ready=0, no word accepted; out_ready=1 -> next edge out_valid=0, in_ready=1.
- Reset mid-S_CALC of the '5' byte of the CRC-32 frame -> out_valid never asserts. A new full frame afterwards -> 0xCBF43926.
- Single-word frame with in_first=in_last=1, data 0x00, CRC-32 config -> 0xD202EF8D. Then in_first asserted mid-frame after '1234' followed by "123456789" -> 0xCBF43926.
